onehot_decoder_seq: RTL



---
 rtl/onehot_decoder_seq.sv | 85 ++++++++
 1 files changed

// File: rtl/onehot_decoder_seq.sv
// Binary-to-one-hot decoder with registered outputs.
// Direct mode latches a select value on load; scan mode rotates the active line with a programmable dwell.
module onehot_decoder_seq #(
  parameter  int SEL_W   = 2,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               e,
  input  logic               mode,
  input  logic [SEL_W-1:0]   s,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  mode_e              mode_q, mode_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    mode_d = mode_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    y_d    = '0;

    if (e) begin
      mode_d = mode_e'(mode);
      if (mode) begin
        // The first scan cycle after direct mode only restarts the dwell count.
        if (mode_q == MODE_DIRECT) begin
          cnt_d = '0;
        end else if (cnt_q >= dwell) begin
          cnt_d  = '0;
          wrap_d = (idx_q == LAST_IDX);
          idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end else begin
        cnt_d = '0;
        if (load) begin
          idx_d = s;
        end
      end
      y_d = OUT_W'(1) << idx_d;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DIRECT;
      idx_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
